wb_bus_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter. Shares a single memory-side Wishbone port between the CPU instruction-fetch master (wbi) and the data master (wbd).
- Sits between cpu_assembled's wbi/wbd ports and a unified memory model or RAM controller.
- Arbitration is round-robin. Grant is locked for a whole bus cycle (cyc).
- A watchdog terminates slave transfers that never acknowledge.

---
 rtl/wb_arb_pkg.sv | 11 +
 rtl/wb_arb_watchdog.sv | 35 +++
 rtl/wb_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} arb_state_t;
    typedef enum logic {MST_I, MST_D} mst_id_t;

    localparam int ARB_AW      = 32;
    localparam int ARB_DW      = 32;
    localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-beat wait counter; expire fires on the last allowed wait cycle.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // Saturates at LAST so a stalled beat never wraps back to zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (clr)
                    cnt <= '0;
                else if (en && (cnt != LAST))
                    cnt <= cnt + 1'b1;
            end

            assign expire = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between the instruction
// and data masters; grant is held for a whole cyc, with a stall watchdog.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wbi_cyc_i,
    input  logic            wbi_stb_i,
    input  logic            wbi_we_i,
    input  logic [AW-1:0]   wbi_adr_i,
    input  logic [DW/8-1:0] wbi_sel_i,
    input  logic [DW-1:0]   wbi_dat_i,
    output logic [DW-1:0]   wbi_dat_o,
    output logic            wbi_ack_o,
    output logic            wbi_err_o,
    input  logic            wbd_cyc_i,
    input  logic            wbd_stb_i,
    input  logic            wbd_we_i,
    input  logic [AW-1:0]   wbd_adr_i,
    input  logic [DW/8-1:0] wbd_sel_i,
    input  logic [DW-1:0]   wbd_dat_i,
    output logic [DW-1:0]   wbd_dat_o,
    output logic            wbd_ack_o,
    output logic            wbd_err_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic            wbs_we_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW/8-1:0] wbs_sel_o,
    output logic [DW-1:0]   wbs_dat_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i
);

    localparam int SW = DW / 8;

    arb_state_t state, state_nxt;
    mst_id_t    last_grant, last_nxt;

    logic          granted, own_d, expire, wd_clr, wd_en;
    logic          own_cyc, own_stb, own_we, own_ack, own_err;
    logic [AW-1:0] own_adr;
    logic [SW-1:0] own_sel;
    logic [DW-1:0] own_dat;

    assign granted = (state == GNT_I) || (state == GNT_D);
    assign own_d   = (state == GNT_D);

    assign own_cyc = own_d ? wbd_cyc_i : wbi_cyc_i;
    assign own_stb = own_d ? wbd_stb_i : wbi_stb_i;
    assign own_we  = own_d ? wbd_we_i  : wbi_we_i;
    assign own_adr = own_d ? wbd_adr_i : wbi_adr_i;
    assign own_sel = own_d ? wbd_sel_i : wbi_sel_i;
    assign own_dat = own_d ? wbd_dat_i : wbi_dat_i;

    // A slave response after the master has dropped cyc is swallowed.
    assign own_ack = wbs_ack_i & own_cyc;
    assign own_err = (wbs_err_i & own_cyc) | expire;

    assign wd_clr = !granted || wbs_ack_i || wbs_err_i;
    assign wd_en  = granted && own_cyc && own_stb && !wbs_ack_i && !wbs_err_i;

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= MST_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (wbi_cyc_i && wbd_cyc_i) begin
                    if (last_grant == MST_I) begin
                        state_nxt = GNT_D;
                        last_nxt  = MST_D;
                    end else begin
                        state_nxt = GNT_I;
                        last_nxt  = MST_I;
                    end
                end else if (wbi_cyc_i) begin
                    state_nxt = GNT_I;
                    last_nxt  = MST_I;
                end else if (wbd_cyc_i) begin
                    state_nxt = GNT_D;
                    last_nxt  = MST_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!own_cyc)
                    state_nxt = IDLE;
                else if (expire)
                    state_nxt = ABORT;
            end
            ABORT: begin
                // last_grant still names the aborted master
                if (!((last_grant == MST_D) ? wbd_cyc_i : wbi_cyc_i))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_adr_o = '0;
        wbs_sel_o = '0;
        wbs_dat_o = '0;
        wbi_dat_o = '0;
        wbi_ack_o = 1'b0;
        wbi_err_o = 1'b0;
        wbd_dat_o = '0;
        wbd_ack_o = 1'b0;
        wbd_err_o = 1'b0;
        if (granted) begin
            wbs_cyc_o = own_cyc;
            wbs_stb_o = own_stb;
            wbs_we_o  = own_we;
            wbs_adr_o = own_adr;
            wbs_sel_o = own_sel;
            wbs_dat_o = own_dat;
            if (own_d) begin
                wbd_dat_o = wbs_dat_i;
                wbd_ack_o = own_ack;
                wbd_err_o = own_err;
            end else begin
                wbi_dat_o = wbs_dat_i;
                wbi_ack_o = own_ack;
                wbi_err_o = own_err;
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle model
// of the arbitration rules (owner / aborted / wait count per master index).
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // index 0 = instruction master, index 1 = data master
    logic [1:0]         cyc, stb, we;
    logic [1:0][AW-1:0] adr;
    logic [1:0][SW-1:0] sel;
    logic [1:0][DW-1:0] wdat;
    logic               sack, serr;
    logic [DW-1:0]      sdat;

    logic [DW-1:0] i_rdat, d_rdat, wbs_dat_o;
    logic          i_ack, i_err, d_ack, d_err;
    logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0] wbs_adr_o;
    logic [SW-1:0] wbs_sel_o;

    int checks = 0;
    int errors = 0;

    int owner;
    bit aborted;
    int last;
    int waits;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbi_cyc_i (cyc[0]),
        .wbi_stb_i (stb[0]),
        .wbi_we_i  (we[0]),
        .wbi_adr_i (adr[0]),
        .wbi_sel_i (sel[0]),
        .wbi_dat_i (wdat[0]),
        .wbi_dat_o (i_rdat),
        .wbi_ack_o (i_ack),
        .wbi_err_o (i_err),
        .wbd_cyc_i (cyc[1]),
        .wbd_stb_i (stb[1]),
        .wbd_we_i  (we[1]),
        .wbd_adr_i (adr[1]),
        .wbd_sel_i (sel[1]),
        .wbd_dat_i (wdat[1]),
        .wbd_dat_o (d_rdat),
        .wbd_ack_o (d_ack),
        .wbd_err_o (d_err),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (sdat),
        .wbs_ack_i (sack),
        .wbs_err_i (serr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; aborted = 0; last = 0; waits = 0;
    endtask

    function automatic bit model_timeout();
        return owner >= 0 && !aborted && cyc[owner] && stb[owner] && !sack && !serr
               && waits == TO - 1;
    endfunction

    task automatic model_check();
        logic [2+SW:0]   e_ctl;
        logic [AW-1:0]   e_adr;
        logic [DW-1:0]   e_wd;
        logic [1:0]      e_ack, e_err;
        logic [1:0][DW-1:0] e_rd;
        e_ctl = '0; e_adr = '0; e_wd = '0; e_ack = '0; e_err = '0; e_rd = '0;
        if (owner >= 0 && !aborted) begin
            e_ctl        = {cyc[owner], stb[owner], we[owner], sel[owner]};
            e_adr        = adr[owner];
            e_wd         = wdat[owner];
            e_ack[owner] = sack & cyc[owner];
            e_err[owner] = (serr & cyc[owner]) | model_timeout();
            e_rd[owner]  = sdat;
        end
        chk("m_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}, e_ctl);
        chk("m_adr", wbs_adr_o, e_adr);
        chk("m_wdat", wbs_dat_o, e_wd);
        chk("m_ack_err", {i_ack, i_err, d_ack, d_err}, {e_ack[0], e_err[0], e_ack[1], e_err[1]});
        chk("m_i_rdat", i_rdat, e_rd[0]);
        chk("m_d_rdat", d_rdat, e_rd[1]);
    endtask

    task automatic model_step();
        if (owner < 0) begin
            if (cyc == 2'b11) owner = 1 - last;
            else if (cyc[0]) owner = 0;
            else if (cyc[1]) owner = 1;
            if (owner >= 0) begin last = owner; waits = 0; end
        end else if (aborted) begin
            if (!cyc[owner]) begin owner = -1; aborted = 0; end
        end else if (!cyc[owner]) begin
            owner = -1;
        end else if (model_timeout()) begin
            aborted = 1;
        end else if (sack || serr) begin
            waits = 0;
        end else if (stb[owner] && waits < TO - 1) begin
            waits++;
        end
    endtask

    // check the cycle at the falling edge, advance the model, land at posedge+1
    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_rand(input int n);
        for (int m = 0; m < 2; m++) begin
            if (cyc[m]) begin
                if ($urandom % 10 == 0) begin
                    cyc[m] = 1'b0; stb[m] = 1'b0;
                end else begin
                    stb[m] = ($urandom % 4) != 0;
                end
            end else if ($urandom % 4 == 0) begin
                cyc[m] = 1'b1; stb[m] = 1'b1;
            end
            adr[m]  = $urandom;
            wdat[m] = $urandom;
            sel[m]  = SW'($urandom);
            we[m]   = $urandom % 2;
        end
        sack = (n % 400 < 200) ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
        serr = ($urandom % 40 == 0);
        sdat = $urandom;
    endtask

    initial begin
        int acks;
        cyc = '0; stb = '0; we = '0; adr = '0; sel = '0; wdat = '0;
        sack = 1'b0; serr = 1'b0; sdat = '0;
        model_reset();
        #1;
        chk("rst_wbs", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o}, '0);
        chk("rst_mst", {i_ack, i_err, d_ack, d_err, i_rdat, d_rdat}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single instruction read
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h100; sel[0] = 4'hF;
        #1 chk("t1_idle_cyc", wbs_cyc_o, 0);
        tick();
        chk("t1_adr", wbs_adr_o, 32'h100);
        chk("t1_stb", wbs_stb_o, 1);
        tick(); tick();
        sack = 1; sdat = 32'hDEADBEEF;
        #1;
        chk("t1_ack", i_ack, 1);
        chk("t1_dat", i_rdat, 32'hDEADBEEF);
        chk("t1_dack", d_ack, 0);
        tick();
        sack = 0; cyc[0] = 0; stb[0] = 0;
        tick(); tick();

        // first tie after reset goes to D, then alternates
        do_reset();
        cyc = 2'b11; stb = 2'b11; adr[0] = 32'h1000; adr[1] = 32'h2000;
        #1 chk("t2_idle", wbs_cyc_o, 0);
        tick();
        chk("t2_first_d", wbs_adr_o, 32'h2000);
        sack = 1;
        tick();
        sack = 0; cyc[1] = 0; stb[1] = 0;
        #1 chk("t2_drop", wbs_cyc_o, 0);
        tick();
        chk("t2_gap", wbs_cyc_o, 0);
        tick();
        chk("t2_then_i", {wbs_cyc_o, wbs_adr_o}, {1'b1, 32'h1000});
        cyc[0] = 0; stb[0] = 0;
        tick();
        cyc = 2'b11; stb = 2'b11;
        tick();
        chk("t2_tie2_d", wbs_adr_o, 32'h2000);
        cyc = 0; stb = 0;
        tick();

        // grant lock across four D beats while I waits
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h3000;
        tick();
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h4000;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            adr[1] = 32'h3000 + 32'(4 * k); stb[1] = 1; sack = 1;
            #1;
            chk("t3_adr", wbs_adr_o, 32'h3000 + 32'(4 * k));
            chk("t3_iack", i_ack, 0);
            acks += int'(d_ack);
            tick();
            sack = 0; stb[1] = 0;
            tick();
        end
        chk("t3_acks", acks, 4);
        cyc[1] = 0;
        #1 chk("t3_rel", wbs_cyc_o, 0);
        tick();
        chk("t3_gap", wbs_cyc_o, 0);
        tick();
        chk("t3_i_gnt", {wbs_cyc_o, wbs_adr_o}, {1'b1, 32'h4000});

        // watchdog: I never acknowledged
        for (int k = 1; k <= TO; k++) begin
            #1 chk("t4_err", i_err, (k == TO) ? 1 : 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_abort_cyc", wbs_cyc_o, 0);
            chk("t4_abort_err", i_err, 0);
            tick();
        end
        cyc[0] = 0; stb[0] = 0;
        tick();
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h5000;
        tick();
        chk("t4_regrant", wbs_cyc_o, 1);

        // ack on the expiry cycle wins
        for (int k = 1; k < TO; k++) tick();
        sack = 1;
        #1;
        chk("t5_ack", i_ack, 1);
        chk("t5_err", i_err, 0);
        tick();
        sack = 0;
        #1 chk("t5_no_abort", wbs_cyc_o, 1);
        cyc[0] = 0; stb[0] = 0;
        tick();

        // async reset mid transfer
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h6000;
        tick();
        sack = 1;
        #1 chk("t6_pre_ack", d_ack, 1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("t6_wbs", {wbs_cyc_o, wbs_stb_o, wbs_adr_o}, '0);
        chk("t6_mst", {d_ack, d_err, i_ack, i_err}, '0);
        sack = 0; cyc = 0; stb = 0;
        @(posedge clk);
        #1 rst_n = 1;
        cyc = 2'b11; stb = 2'b11; adr[0] = 32'h7000; adr[1] = 32'h8000;
        tick();
        chk("t6_tie_d", wbs_adr_o, 32'h8000);
        cyc = 0; stb = 0;
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            drive_rand(n);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
